ram_responder: RTL and testbench

//  RAM-side end of the ram interface driven by memory_control.

---
 rtl/ram_responder_if.sv | 17 +
 rtl/ram_responder.sv | 93 +++++++++
 tb/tb_ram_responder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_responder_if.sv
// Shared RAM-port types and the bus between memory_control and the RAM responder.
package cpu_types_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

interface ram_responder_if;
  import cpu_types_pkg::*;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;

  modport master (output ramREN, ramWEN, ramaddr, ramstore, input ramload, ramstate);
  modport slave  (input ramREN, ramWEN, ramaddr, ramstore, output ramload, ramstate);
endinterface

// File: rtl/ram_responder.sv
// RAM-side responder: word-addressed array with programmable access latency.
// Status is a Mealy decode of the live request against the latched one.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int LAT    = 2
) (
  input  logic           CLK,
  input  logic           nRST,
  ram_responder_if.slave bus
);

  typedef enum logic {IDLE, WAIT} st_t;

  st_t              st, st_n;
  logic [3:0]       cnt, cnt_n;
  logic [31:0]      l_addr, l_addr_n;
  logic             l_wen, l_wen_n;
  logic [31:0]      l_data, l_data_n;

  logic [31:0]      mem [0:(2**ADDR_W)-1];
  logic [ADDR_W-1:0] idx;
  logic             req, err, same;
  ramstate_t        rs;

  assign idx = bus.ramaddr[ADDR_W+1:2];

  // State register: latched request and latency counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      st     <= IDLE;
      cnt    <= '0;
      l_addr <= '0;
      l_wen  <= 1'b0;
      l_data <= '0;
    end else begin
      st     <= st_n;
      cnt    <= cnt_n;
      l_addr <= l_addr_n;
      l_wen  <= l_wen_n;
      l_data <= l_data_n;
    end
  end

  // Array write on the ACCESS cycle of a write; contents are never reset.
  always_ff @(posedge CLK) begin
    if (rs == ACCESS && bus.ramWEN) mem[idx] <= bus.ramstore;
  end

  // Request decode and status priority (ERROR > FREE > ACCESS > BUSY).
  always_comb begin
    req  = bus.ramREN ^ bus.ramWEN;
    err  = (bus.ramREN & bus.ramWEN) |
           (req & ((bus.ramaddr[1:0] != 2'b00) || ((bus.ramaddr >> (ADDR_W + 2)) != '0)));
    same = (st == WAIT) & req & (bus.ramaddr == l_addr) & (bus.ramWEN == l_wen) &
           (!l_wen | (bus.ramstore == l_data));
    if (err)                                   rs = ERROR;
    else if (!req)                             rs = FREE;
    else if ((same && cnt == 4'd0) || LAT == 0) rs = ACCESS;
    else                                       rs = BUSY;
  end

  // Next-state: count down a held request, restart on any change.
  always_comb begin
    st_n     = st;
    cnt_n    = cnt;
    l_addr_n = l_addr;
    l_wen_n  = l_wen;
    l_data_n = l_data;
    case (rs)
      BUSY: begin
        if (same) begin
          cnt_n = cnt - 4'd1;
        end else begin
          st_n     = WAIT;
          cnt_n    = (LAT > 0) ? 4'(LAT - 1) : 4'd0;
          l_addr_n = bus.ramaddr;
          l_wen_n  = bus.ramWEN;
          l_data_n = bus.ramstore;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // Outputs: status and read data, data gated to read ACCESS cycles.
  always_comb begin
    bus.ramstate = rs;
    bus.ramload  = (rs == ACCESS && bus.ramREN) ? mem[idx] : '0;
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: LAT=2 instance plus a LAT=0 instance.
module tb_ram_responder;
  import cpu_types_pkg::*;

  localparam logic [5:0] BBA = {BUSY, BUSY, ACCESS};

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   errors = 0;
  int   checks = 0;

  ram_responder_if bus ();
  ram_responder_if bus0 ();

  ram_responder #(.ADDR_W(14), .LAT(2)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  ram_responder #(.ADDR_W(14), .LAT(0)) dut0 (.CLK(CLK), .nRST(nRST), .bus(bus0));

  always #5 CLK = ~CLK;

  task automatic cyc(input logic ren, input logic wen, input logic [31:0] addr,
                     input logic [31:0] data);
    @(negedge CLK);
    bus.ramREN = ren; bus.ramWEN = wen; bus.ramaddr = addr; bus.ramstore = data;
    #1;
  endtask

  // Holds one request for three cycles and records the status sequence.
  task automatic run_access(input logic ren, input logic wen, input logic [31:0] addr,
                            input logic [31:0] data, output logic [5:0] seq,
                            output logic [31:0] load);
    seq = '0;
    load = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      cyc(ren, wen, addr, data);
      seq = {seq[3:0], bus.ramstate};
      if (i == 2) load = bus.ramload;
    end
  endtask

  task automatic test_reset();
    logic [5:0] seq;
    logic [31:0] load;
    bus.ramREN = 0; bus.ramWEN = 0; bus.ramaddr = '0; bus.ramstore = '0;
    bus0.ramREN = 0; bus0.ramWEN = 0; bus0.ramaddr = '0; bus0.ramstore = '0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    #1;
    checks++;
    if (bus.ramstate !== FREE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", bus.ramstate, FREE);
    end
    checks++;
    if (bus.ramload !== 32'h0) begin
      errors++; $display("FAIL reset_load: got %h expected 00000000", bus.ramload);
    end
    cyc(1, 0, 32'h0, 32'h0);
    checks++;
    if (bus.ramstate !== BUSY) begin
      errors++; $display("FAIL pre_reset_busy: got %0d expected %0d", bus.ramstate, BUSY);
    end
    @(negedge CLK);
    nRST = 1'b0; bus.ramREN = 0;
    #1;
    checks++;
    if (bus.ramstate !== FREE) begin
      errors++; $display("FAIL reset_mid_wait: got %0d expected %0d", bus.ramstate, FREE);
    end
    @(negedge CLK);
    nRST = 1'b1;
    run_access(1, 0, 32'h0, 32'h0, seq, load);
    checks++;
    if (seq !== BBA) begin
      errors++; $display("FAIL restart_seq: got %b expected %b", seq, BBA);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_write_read();
    logic [5:0] seq;
    logic [31:0] load;
    run_access(0, 1, 32'h40, 32'hDEADBEEF, seq, load);
    checks++;
    if (seq !== BBA) begin
      errors++; $display("FAIL write_seq: got %b expected %b", seq, BBA);
    end
    run_access(1, 0, 32'h40, 32'h0, seq, load);
    checks++;
    if (seq !== BBA) begin
      errors++; $display("FAIL read_seq: got %b expected %b", seq, BBA);
    end
    checks++;
    if (load !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_after_write: got %h expected deadbeef", load);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] seq;
    logic [31:0] load;
    run_access(0, 1, 32'h0, 32'hA0A0A0A0, seq, load);
    run_access(0, 1, 32'h4, 32'h0B0B0B0B, seq, load);
    cyc(0, 0, 0, 0);
    run_access(1, 0, 32'h0, 32'h0, seq, load);
    checks++;
    if (seq !== BBA) begin
      errors++; $display("FAIL b2b_seq0: got %b expected %b", seq, BBA);
    end
    checks++;
    if (load !== 32'hA0A0A0A0) begin
      errors++; $display("FAIL b2b_load0: got %h expected a0a0a0a0", load);
    end
    run_access(1, 0, 32'h4, 32'h0, seq, load);
    checks++;
    if (seq !== BBA) begin
      errors++; $display("FAIL b2b_seq1: got %b expected %b", seq, BBA);
    end
    checks++;
    if (load !== 32'h0B0B0B0B) begin
      errors++; $display("FAIL b2b_load1: got %h expected 0b0b0b0b", load);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_restart_drop();
    logic [5:0] seq;
    logic [31:0] load;
    cyc(0, 1, 32'h80, 32'h1);
    checks++;
    if (bus.ramstate !== BUSY) begin
      errors++; $display("FAIL restart_first: got %0d expected %0d", bus.ramstate, BUSY);
    end
    run_access(0, 1, 32'h80, 32'h2, seq, load);
    checks++;
    if (seq !== BBA) begin
      errors++; $display("FAIL restart_seq: got %b expected %b", seq, BBA);
    end
    cyc(0, 0, 0, 0);
    run_access(1, 0, 32'h80, 32'h0, seq, load);
    checks++;
    if (load !== 32'h2) begin
      errors++; $display("FAIL restart_readback: got %h expected 00000002", load);
    end
    run_access(0, 1, 32'h84, 32'h84848484, seq, load);
    cyc(0, 1, 32'h84, 32'h99);
    cyc(0, 0, 32'h84, 32'h99);
    checks++;
    if (bus.ramstate !== FREE) begin
      errors++; $display("FAIL drop_free: got %0d expected %0d", bus.ramstate, FREE);
    end
    run_access(1, 0, 32'h84, 32'h0, seq, load);
    checks++;
    if (load !== 32'h84848484) begin
      errors++; $display("FAIL drop_readback: got %h expected 84848484", load);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_errors();
    logic [5:0] seq;
    logic [31:0] load;
    for (int unsigned i = 0; i < 3; i++) begin
      cyc(1, 1, 32'h40, 32'h12345678);
      checks++;
      if (bus.ramstate !== ERROR) begin
        errors++; $display("FAIL err_both: got %0d expected %0d", bus.ramstate, ERROR);
      end
    end
    cyc(1, 0, 32'h2, 32'h0);
    checks++;
    if (bus.ramstate !== ERROR || bus.ramload !== 32'h0) begin
      errors++; $display("FAIL err_misaligned: got %0d/%h expected %0d/00000000",
                         bus.ramstate, bus.ramload, ERROR);
    end
    cyc(0, 1, 32'h42, 32'h55555555);
    checks++;
    if (bus.ramstate !== ERROR) begin
      errors++; $display("FAIL err_misaligned_wr: got %0d expected %0d", bus.ramstate, ERROR);
    end
    cyc(1, 0, 32'h10000, 32'h0);
    checks++;
    if (bus.ramstate !== ERROR) begin
      errors++; $display("FAIL err_range: got %0d expected %0d", bus.ramstate, ERROR);
    end
    for (int unsigned i = 0; i < 3; i++) cyc(0, 1, 32'h10040, 32'h66666666);
    checks++;
    if (bus.ramstate !== ERROR) begin
      errors++; $display("FAIL err_range_wr: got %0d expected %0d", bus.ramstate, ERROR);
    end
    cyc(0, 0, 0, 0);
    run_access(1, 0, 32'h40, 32'h0, seq, load);
    checks++;
    if (load !== 32'hDEADBEEF) begin
      errors++; $display("FAIL err_no_write: got %h expected deadbeef", load);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_access();
    logic [5:0] seq;
    logic [31:0] load;
    run_access(0, 1, 32'h100, 32'h11111111, seq, load);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 32'h100, 32'h22222222);
    cyc(0, 1, 32'h100, 32'h22222222);
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    checks++;
    if (bus.ramstate !== BUSY) begin
      errors++; $display("FAIL reset_kills_access: got %0d expected %0d", bus.ramstate, BUSY);
    end
    @(negedge CLK);
    bus.ramWEN = 0;
    nRST = 1'b1;
    run_access(1, 0, 32'h100, 32'h0, seq, load);
    checks++;
    if (load !== 32'h11111111) begin
      errors++; $display("FAIL reset_no_commit: got %h expected 11111111", load);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_lat0();
    logic [31:0] addr_v [4] = '{32'h8, 32'hC, 32'h8, 32'hC};
    logic [31:0] data_v [4] = '{32'h77, 32'h88, 32'h0, 32'h0};
    logic [31:0] load_v [4] = '{32'h0, 32'h0, 32'h77, 32'h88};
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge CLK);
      bus0.ramREN = (i >= 2); bus0.ramWEN = (i < 2);
      bus0.ramaddr = addr_v[i]; bus0.ramstore = data_v[i];
      #1;
      checks++;
      if (bus0.ramstate !== ACCESS || bus0.ramload !== load_v[i]) begin
        errors++; $display("FAIL lat0_word%0d: got %0d/%h expected %0d/%h",
                           i, bus0.ramstate, bus0.ramload, ACCESS, load_v[i]);
      end
    end
    @(negedge CLK);
    bus0.ramREN = 0; bus0.ramWEN = 0;
    #1;
    checks++;
    if (bus0.ramstate !== FREE) begin
      errors++; $display("FAIL lat0_idle: got %0d expected %0d", bus0.ramstate, FREE);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_restart_drop();
    test_errors();
    test_reset_mid_access();
    test_lat0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
